inst_mem_loadable: RTL

Parametrised, synchronous-read instruction memory for the pipelined MIPS core. It replaces the hard-coded combinational instruction ROM.
- Fetch port: one-cycle registered read, with stall and fault reporting.
- Load port: streaming valid/ready port that writes a program into the array at run time, so new programs need no re-synthesis.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 18 +
 rtl/sp_ram_1r1w.sv | 53 +++++
 rtl/inst_mem_loadable.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core's instruction memory.
//   MIPS_NOP : canonical "no instruction" word (sll $0,$0,0 encodes as zero)
//   state_t  : run/load mode of the loadable instruction memory
// ---------------------------------------------------------------------------
package mips_pkg;

  // All-zero word decodes as a harmless NOP in the MIPS ISA.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // RUN serves fetches; LOAD streams a new program into the array.
  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/sp_ram_1r1w.sv
// ---------------------------------------------------------------------------
// sp_ram_1r1w
// Single-write, single-read storage array with a registered read port,
// written so that synthesis maps it onto block RAM.
// Ports:
//   clk       : clock
//   i_wrEn    : write enable
//   i_wrAddr  : write word index
//   i_wrData  : write data
//   i_rdEn    : read enable; o_rdData holds its value while low
//   i_rdAddr  : read word index
//   o_rdData  : registered read data (one cycle after i_rdEn)
// ---------------------------------------------------------------------------
module sp_ram_1r1w #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter                        INIT_FILE  = "",
   parameter logic [DATA_WIDTH-1:0] INIT_WORD  = '0,
   localparam int                   IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_wrEn,
   input  logic [IDX_W-1:0]      i_wrAddr,
   input  logic [DATA_WIDTH-1:0] i_wrData,
   input  logic                  i_rdEn,
   input  logic [IDX_W-1:0]      i_rdAddr,
   output logic [DATA_WIDTH-1:0] o_rdData
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdData;

   // Power-up contents: every word is INIT_WORD. Reset never touches the array.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         r_mem[i] = INIT_WORD;
      end
   end

   // Write port and registered read port share one clocked process; the read
   // register has no reset so the pair maps onto a block RAM primitive.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
      if (i_rdEn) begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// inst_mem_loadable
// Run-time loadable instruction memory sitting between the IF-stage PC and
// the IF/ID register. Fetches have one cycle of latency; a streaming load
// port rewrites the program without re-synthesis.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   fetch_addr     : byte address from the PC
//   fetch_req      : fetch request
//   fetch_stall    : hold current fetch outputs (IF stall, beats fetch_req)
//   instruction    : fetched word, NOP_WORD whenever inst_valid is low
//   inst_valid     : instruction holds a real fetched word
//   addr_fault     : last sampled request was misaligned or out of range
//   load_start     : pulse, begin (or restart) a program download
//   load_valid     : load_data carries a program word
//   load_data      : program word
//   load_last      : final word of the download
//   load_ready     : high while downloading
//   load_done      : one-cycle pulse when a download completes
//   load_overflow  : sticky, words beyond DEPTH were discarded
//   load_count     : words written by the current or most recent download
// ---------------------------------------------------------------------------
module inst_mem_loadable
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(MIPS_NOP),
  parameter                        INIT_FILE  = "",
  localparam int                   IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_req,
  input  logic                  fetch_stall,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic                  addr_fault,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_overflow,
  output logic [IDX_W:0]        load_count
);

  localparam logic [IDX_W:0] PTR_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0] PTR_FULL = (IDX_W + 1)'(DEPTH);

  state_t                r_state;
  logic [IDX_W:0]        r_wrPtr;
  logic                  r_loadDone;
  logic                  r_loadOverflow;
  logic                  r_instValid;
  logic                  r_addrFault;

  logic [IDX_W-1:0]      w_fetchIdx;
  logic                  w_misaligned;
  logic                  w_outOfRange;
  logic                  w_fault;
  logic                  w_ramRdEn;
  logic                  w_ramWrEn;
  logic                  w_ramFull;
  logic [DATA_WIDTH-1:0] w_ramRdData;

  // Address decode: word index from the byte address, fault when the low two
  // bits are set or any bit above the word index is set.
  assign w_fetchIdx   = fetch_addr[IDX_W+1:2];
  assign w_misaligned = |fetch_addr[1:0];
  assign w_outOfRange = |(fetch_addr >> (IDX_W + 2));
  assign w_fault      = w_misaligned | w_outOfRange;

  // The RAM read register only advances on an accepted, fault-free fetch in
  // RUN, so it naturally holds the last word through stalls and downloads.
  assign w_ramRdEn = (r_state == RUN) && fetch_req && !fetch_stall && !w_fault;

  // Writes happen only in LOAD, never in a restart cycle, never past the end.
  // The pointer doubles as the word count: it saturates at DEPTH.
  assign w_ramFull = (r_wrPtr == PTR_FULL);
  assign w_ramWrEn = (r_state == LOAD) && !load_start && load_valid && !w_ramFull;

  sp_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE),
    .INIT_WORD  (NOP_WORD)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (w_ramWrEn),
    .i_wrAddr (r_wrPtr[IDX_W-1:0]),
    .i_wrData (load_data),
    .i_rdEn   (w_ramRdEn),
    .i_rdAddr (w_fetchIdx),
    .o_rdData (w_ramRdData)
  );

  // RUN/LOAD controller with the download pointer, sticky overflow and the
  // single-cycle done pulse. A start while loading restarts the download and
  // swallows any word offered in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= RUN;
      r_wrPtr        <= '0;
      r_loadOverflow <= 1'b0;
      r_loadDone     <= 1'b0;
    end else begin
      r_loadDone <= 1'b0;
      case (r_state)
        RUN: begin
          if (load_start) begin
            r_state        <= LOAD;
            r_wrPtr        <= '0;
            r_loadOverflow <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            r_wrPtr        <= '0;
            r_loadOverflow <= 1'b0;
          end else if (load_valid) begin
            if (w_ramFull) begin
              r_loadOverflow <= 1'b1;
            end else begin
              r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (load_last) begin
              r_state    <= RUN;
              r_loadDone <= 1'b1;
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Fetch status registers. Stall freezes them in RUN; in LOAD the valid
  // flag drops regardless of stall so no stale word leaks into IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instValid <= 1'b0;
      r_addrFault <= 1'b0;
    end else if (r_state == LOAD) begin
      r_instValid <= 1'b0;
    end else if (!fetch_stall) begin
      if (fetch_req) begin
        r_instValid <= !w_fault;
        r_addrFault <= w_fault;
      end else begin
        r_instValid <= 1'b0;
        r_addrFault <= 1'b0;
      end
    end
  end

  // The RAM output register is not reset, so the word is gated by the valid
  // flag; every "no instruction" case then reads as NOP_WORD.
  assign instruction   = r_instValid ? w_ramRdData : NOP_WORD;
  assign inst_valid    = r_instValid;
  assign addr_fault    = r_addrFault;
  assign load_ready    = (r_state == LOAD);
  assign load_done     = r_loadDone;
  assign load_overflow = r_loadOverflow;
  assign load_count    = r_wrPtr;

endmodule
